// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: byte-in / result-out bundle for the UART command parser.
//   i_rx_data/i_rx_valid : received byte and its one-cycle strobe
//   o_data/o_meta/o_stb  : last accepted payload + meta, strobe on update
//   o_err/o_err_cnt      : malformed-line pulse and saturating counter
//   o_busy               : parser is mid-line
// slave modport = parser side, master modport = byte source / result sink.
interface uart_cmd_parser_if #(
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic [1:0]            o_meta;
  logic                  o_stb;
  logic                  o_err;
  logic [7:0]            o_err_cnt;
  logic                  o_busy;

  modport slave (
    input  i_rx_data, i_rx_valid,
    output o_data, o_meta, o_stb, o_err, o_err_cnt, o_busy
  );

  modport master (
    output i_rx_data, i_rx_valid,
    input  o_data, o_meta, o_stb, o_err, o_err_cnt, o_busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses ASCII lines of the form "R<m>:<hex x NUM_NIB>\n".
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   bus.slave  : i_rx_data/i_rx_valid in; o_data, o_meta, o_stb, o_err,
//                o_err_cnt, o_busy out (all outputs registered)
// Meta and payload are collected in shadow registers and only committed to
// o_data/o_meta when the terminating '\n' arrives, so a bad line never
// disturbs the last good result. '\r' is transparent in every state.
module uart_cmd_parser #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_NIB    = DATA_WIDTH / 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_parser_if.slave     bus
);

  localparam int CW = $clog2(NUM_NIB + 1);

  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_COLON = 8'h3A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_META,
    S_COLON,
    S_DATA,
    S_TERM
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            meta_sh_q, meta_sh_d;
  logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            meta_q, meta_d;
  logic                  stb_q, stb_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  busy_q, busy_d;

  logic [4:0]            hex;    // {valid, nibble}
  logic [CW-1:0]         cnt_inc;
  logic                  bad;

  // {1, value} for an ASCII hex digit of either case, {0, x} otherwise
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    logic [7:0] t;
    hex_dec = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = c - 8'h30;
      hex_dec = {1'b1, t[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      t = c - 8'h37;
      hex_dec = {1'b1, t[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      t = c - 8'h57;
      hex_dec = {1'b1, t[3:0]};
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    meta_sh_d = meta_sh_q;
    data_sh_d = data_sh_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    meta_d    = meta_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bad       = 1'b0;
    hex       = hex_dec(bus.i_rx_data);
    cnt_inc   = cnt_q + CW'(1);

    if (bus.i_rx_valid && bus.i_rx_data != CH_CR) begin
      case (state_q)
        S_IDLE: begin
          // anything but 'R' is blank line or pre-sync noise: drop silently
          if (bus.i_rx_data == CH_R) state_d = S_META;
        end
        S_META: begin
          if (bus.i_rx_data >= 8'h30 && bus.i_rx_data <= 8'h33) begin
            meta_sh_d = bus.i_rx_data[1:0];
            state_d   = S_COLON;
          end else begin
            bad = 1'b1;
          end
        end
        S_COLON: begin
          if (bus.i_rx_data == CH_COLON) begin
            data_sh_d = '0;
            cnt_d     = '0;
            state_d   = S_DATA;
          end else begin
            bad = 1'b1;
          end
        end
        S_DATA: begin
          if (hex[4]) begin
            // shift left works for DATA_WIDTH=4 where a part-select would not
            data_sh_d = (data_sh_q << 4) | DATA_WIDTH'(hex[3:0]);
            cnt_d     = cnt_inc;
            if (cnt_inc == CW'(NUM_NIB)) state_d = S_TERM;
          end else begin
            bad = 1'b1;
          end
        end
        S_TERM: begin
          if (bus.i_rx_data == CH_LF) begin
            data_d  = data_sh_q;
            meta_d  = meta_sh_q;
            stb_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            bad = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (bad) begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        // a stray 'R' is most likely the start of the next line: resync on it
        state_d = (bus.i_rx_data == CH_R) ? S_META : S_IDLE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      meta_sh_q <= '0;
      data_sh_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      meta_q    <= '0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      meta_sh_q <= meta_sh_d;
      data_sh_q <= data_sh_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      meta_q    <= meta_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_meta    = meta_q;
  assign bus.o_stb     = stb_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;
  assign bus.o_busy    = busy_q;

endmodule
